// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO master serialising one read/write management frame per command
module mdio_master #(
  parameter int CLK_DIV = 50
) (
  input  logic        msoc_clk,
  input  logic        rst_int_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        phy_mdc,
  output logic        phy_mdio_o,
  output logic        phy_mdio_oe,
  input  logic        phy_mdio_i
);
  typedef enum logic [2:0] {IDLE, PRE, HDR, WTA, WDAT, RTA, RDAT, DONE} state_t;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  state_t      state;
  logic [7:0]  div;
  logic        phase;
  logic [5:0]  bit_cnt;
  logic [5:0]  bit_last;
  logic [15:0] hdr;
  logic [15:0] dat;
  logic        is_write;
  logic        ta_err;
  logic [1:0]  sync;
  logic        mdio_s;
  logic        bit_end;
  logic        last;
  assign mdio_s  = sync[1];
  assign busy    = ~cmd_ready;
  assign bit_end = phase && div == DIV_LAST;
  assign last    = bit_end && bit_cnt == bit_last;
  always_comb
    bit_last = state == PRE ? 6'd31 : state == HDR ? 6'd13 : (state == WTA || state == RTA) ? 6'd1 : 6'd15;
  always_ff @(posedge msoc_clk) begin
    if (!rst_int_n) sync <= 2'b00;
    else sync <= {sync[0], phy_mdio_i};
  end
  // phy_mdio_o always holds the bit currently on the wire; the header register keeps its next bit at [14]
  always_ff @(posedge msoc_clk) begin
    if (!rst_int_n) begin
      state       <= IDLE;
      div         <= 8'd0;
      phase       <= 1'b0;
      bit_cnt     <= 6'd0;
      hdr         <= 16'd0;
      dat         <= 16'd0;
      is_write    <= 1'b0;
      ta_err      <= 1'b0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 16'd0;
      rsp_err     <= 1'b0;
      phy_mdc     <= 1'b0;
      phy_mdio_o  <= 1'b0;
      phy_mdio_oe <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state != IDLE && state != DONE) begin
        div <= div == DIV_LAST ? 8'd0 : div + 8'd1;
        if (div == DIV_LAST) begin
          phase   <= ~phase;
          phy_mdc <= ~phase;
        end
        if (bit_end) bit_cnt <= last ? 6'd0 : bit_cnt + 6'd1;
      end
      case (state)
        IDLE: if (cmd_valid) begin
          state       <= PRE;
          cmd_ready   <= 1'b0;
          hdr         <= {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr, 2'b10};
          dat         <= cmd_wdata;
          is_write    <= cmd_write;
          phy_mdio_o  <= 1'b1;
          phy_mdio_oe <= 1'b1;
        end
        PRE: if (last) begin
          state      <= HDR;
          phy_mdio_o <= hdr[15];
        end
        HDR: if (bit_end) begin
          hdr         <= {hdr[14:0], 1'b0};
          phy_mdio_o  <= last && !is_write ? 1'b0 : hdr[14];
          phy_mdio_oe <= !(last && !is_write);
          if (last) state <= is_write ? WTA : RTA;
        end
        WTA: if (bit_end) begin
          hdr        <= {hdr[14:0], 1'b0};
          phy_mdio_o <= last ? dat[15] : hdr[14];
          if (last) state <= WDAT;
        end
        WDAT: if (bit_end) begin
          dat         <= {dat[14:0], 1'b0};
          phy_mdio_o  <= last ? 1'b0 : dat[14];
          phy_mdio_oe <= !last;
          if (last) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_rdata <= 16'd0;
            rsp_err   <= 1'b0;
          end
        end
        RTA: if (last) begin
          ta_err <= mdio_s;
          state  <= RDAT;
        end
        RDAT: if (bit_end) begin
          dat <= {dat[14:0], mdio_s};
          if (last) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_rdata <= {dat[14:0], mdio_s};
            rsp_err   <= ta_err;
          end
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: scoreboard bench with a behavioural PHY for the MDIO master at CLK_DIV=4
module tb_mdio_master;
  typedef struct {
    logic [15:0] rdata;
    logic        err;
    logic [63:0] o;
    logic [63:0] oe;
    longint      cyc;
  } exp_t;
  logic        msoc_clk;
  logic        rst_int_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        phy_mdc;
  logic        phy_mdio_o;
  logic        phy_mdio_oe;
  logic        phy_mdio_i;
  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          timing_viol = 0;
  int          hold_viol = 0;
  longint      cyc = 0;
  longint      last_acc = 0;
  int          acc_cnt = 0;
  int          frame_id = 0;
  int          rises = 0;
  logic [63:0] got_o;
  logic [63:0] got_oe;
  logic [15:0] phy_rd = 16'd0;
  logic        phy_pres = 1'b1;
  logic        phy_en = 1'b0;
  logic        phy_val = 1'b1;
  mdio_master #(.CLK_DIV(4)) dut (
    .msoc_clk(msoc_clk), .rst_int_n(rst_int_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .phy_mdc(phy_mdc),
    .phy_mdio_o(phy_mdio_o), .phy_mdio_oe(phy_mdio_oe), .phy_mdio_i(phy_mdio_i)
  );
  // open-drain bus with pull-up: master, then PHY, then the pull resistor
  assign phy_mdio_i = phy_mdio_oe ? phy_mdio_o : phy_en ? phy_val : 1'b1;
  initial msoc_clk = 1'b0;
  always #5 msoc_clk = ~msoc_clk;
  always @(posedge msoc_clk) cyc <= cyc + 1;
  always @(posedge phy_mdc) begin
    if (acc_cnt != frame_id) begin
      frame_id = acc_cnt;
      rises = 0;
    end
    if (rises < 64) begin
      got_o[63-rises]  = phy_mdio_o;
      got_oe[63-rises] = phy_mdio_oe;
    end
    rises = rises + 1;
  end
  // bit number 'rises' begins at this falling edge; PHY answers TA bit 47 with 0, then 16 data bits
  always @(negedge phy_mdc) begin
    phy_en  = phy_pres && rises >= 47 && rises <= 63;
    phy_val = rises == 47 ? 1'b0 : (rises >= 48 && rises <= 63) ? phy_rd[63-rises] : 1'b1;
  end
  task automatic issue(input logic w, input logic [4:0] p, input logic [4:0] r, input logic [15:0] d,
                       input logic [15:0] rd, input logic pres, input logic hold, input logic chk_space,
                       input logic exp_rsp);
    int n;
    exp_t e;
    longint t;
    n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_phy_addr = p;
    cmd_reg_addr = r;
    cmd_wdata = d;
    while (!cmd_ready && n < 3000) begin
      @(posedge msoc_clk); #1;
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL accept_timeout cmd_ready=%0b required=1", cmd_ready);
    end
    t = cyc;
    if (chk_space) begin
      checks++;
      if (t - last_acc != 514) begin
        errors++;
        $display("FAIL accept_spacing got=%0d required=514", t - last_acc);
      end
    end
    last_acc = t;
    phy_rd = rd;
    phy_pres = pres;
    e.rdata = w ? 16'h0000 : pres ? rd : 16'hFFFF;
    e.err   = !w && !pres;
    e.o     = {32'hFFFF_FFFF, 2'b01, w ? 2'b01 : 2'b10, p, r, w ? {2'b10, d} : 18'h0};
    e.oe    = w ? 64'hFFFF_FFFF_FFFF_FFFF : {{46{1'b1}}, 18'h0};
    e.cyc   = t + 513;
    if (exp_rsp) sbq.push_back(e);
    @(posedge msoc_clk); #1;
    acc_cnt++;
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_accept busy=%0b ready=%0b required busy=1 ready=0", busy, cmd_ready);
    end
    if (!hold) cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_phy_addr = 5'($urandom);
    cmd_reg_addr = 5'($urandom);
    cmd_wdata = 16'($urandom);
  endtask
  initial begin
    logic pm, po, poe, le;
    logic [15:0] lr;
    exp_t e;
    pm = 1'b0; po = 1'b0; poe = 1'b0; le = 1'b0; lr = 16'd0;
    forever begin
      @(negedge msoc_clk);
      if (pm && phy_mdc && (po != phy_mdio_o || poe != phy_mdio_oe)) timing_viol++;
      pm = phy_mdc; po = phy_mdio_o; poe = phy_mdio_oe;
      if (!rst_int_n) begin
        lr = 16'd0;
        le = 1'b0;
      end else if (rsp_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp at cycle %0d rdata=%h required no response", cyc, rsp_rdata);
        end else begin
          e = sbq.pop_front();
          checks++;
          if (rsp_rdata !== e.rdata) begin errors++; $display("FAIL rsp_rdata got=%h required=%h", rsp_rdata, e.rdata); end
          checks++;
          if (rsp_err !== e.err) begin errors++; $display("FAIL rsp_err got=%0b required=%0b", rsp_err, e.err); end
          checks++;
          if (cyc != e.cyc) begin errors++; $display("FAIL rsp_latency got=%0d required=%0d", cyc, e.cyc); end
          checks++;
          if (rises != 64) begin errors++; $display("FAIL mdc_edges got=%0d required=64", rises); end
          checks++;
          if (got_oe !== e.oe) begin errors++; $display("FAIL frame_oe got=%h required=%h", got_oe, e.oe); end
          checks++;
          if ((got_o & e.oe) !== (e.o & e.oe)) begin errors++; $display("FAIL frame_bits got=%h required=%h", got_o & e.oe, e.o & e.oe); end
        end
        lr = rsp_rdata;
        le = rsp_err;
      end else if (rsp_rdata != lr || rsp_err != le) hold_viol++;
    end
  end
  initial begin
    logic w, pres;
    logic [4:0] p, r;
    logic [15:0] d, rd;
    int n;
    rst_int_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_phy_addr = 5'd0;
    cmd_reg_addr = 5'd0;
    cmd_wdata = 16'd0;
    repeat (3) @(posedge msoc_clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready ready=%0b busy=%0b required 1/0", cmd_ready, busy); end
    checks++;
    if ({phy_mdc, phy_mdio_o, phy_mdio_oe} !== 3'b000) begin errors++; $display("FAIL reset_pins got=%b required=000", {phy_mdc, phy_mdio_o, phy_mdio_oe}); end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'd0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp valid=%0b rdata=%h err=%0b required 0/0000/0", rsp_valid, rsp_rdata, rsp_err);
    end
    rst_int_n = 1'b1;
    repeat (3) @(posedge msoc_clk);
    #1;
    issue(1'b1, 5'd1, 5'd0, 16'h1140, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 5'd7, 5'd2, 16'h0, 16'h004D, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 5'd3, 5'd1, 16'h0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 5'd5, 5'd9, 16'h0, 16'hA5C3, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(1'b1, 5'd9, 5'd4, 16'hBEEF, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    issue(1'b0, 5'd31, 5'd31, 16'h0, 16'h8001, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 5'd2, 5'd3, 16'hFFFF, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    while (cyc < last_acc + 200) begin
      @(posedge msoc_clk); #1;
    end
    rst_int_n = 1'b0;
    @(posedge msoc_clk); #1;
    checks++;
    if (phy_mdc !== 1'b0 || phy_mdio_oe !== 1'b0) begin errors++; $display("FAIL abort_pins mdc=%0b oe=%0b required 0/0", phy_mdc, phy_mdio_oe); end
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_state ready=%0b rsp_valid=%0b required 1/0", cmd_ready, rsp_valid); end
    rst_int_n = 1'b1;
    issue(1'b0, 5'd7, 5'd3, 16'h0, 16'h3C5A, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      w = 1'($urandom);
      p = 5'($urandom);
      r = 5'($urandom);
      d = 16'($urandom);
      rd = 16'($urandom);
      pres = $urandom_range(0, 3) != 0;
      repeat ($urandom_range(0, 20)) @(posedge msoc_clk);
      #1;
      issue(w, p, r, d, rd, pres, 1'b0, 1'b0, 1'b1);
    end
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(posedge msoc_clk);
      n++;
    end
    repeat (4) @(posedge msoc_clk);
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL drain pending=%0d required=0", sbq.size()); end
    checks++;
    if (timing_viol != 0) begin errors++; $display("FAIL mdio_while_mdc_high got=%0d required=0", timing_viol); end
    checks++;
    if (hold_viol != 0) begin errors++; $display("FAIL rsp_hold got=%0d required=0", hold_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
